// File: rtl/riscv_isa_pkg.sv
// RV32I encoding constants and request type shared by the instruction encoder and immediate generator.
// imm_in_range() backs the optional IMM_RANGE_CHECK_EN immediate checking.
package riscv_isa_pkg;

  localparam logic [2:0] OP_ADDI = 3'd0;
  localparam logic [2:0] OP_SRAI = 3'd1;
  localparam logic [2:0] OP_LW   = 3'd2;
  localparam logic [2:0] OP_SW   = 3'd3;
  localparam logic [2:0] OP_BEQ  = 3'd4;

  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADDI = 3'b000;
  localparam logic [2:0] F3_SRX  = 3'b101;
  localparam logic [2:0] F3_LW   = 3'b010;
  localparam logic [2:0] F3_SW   = 3'b010;
  localparam logic [2:0] F3_BEQ  = 3'b000;

  localparam logic [6:0] F7_SRA = 7'b0100000;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [2:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } enc_req_t;

  // Sign-extension tests: a value fits N signed bits when bits [31:N-1] are all equal.
  function automatic logic imm_in_range(input logic [2:0] op, input logic [31:0] imm);
    logic fits12, fits13;
    fits12 = (&imm[31:11]) | ~(|imm[31:11]);
    fits13 = (&imm[31:12]) | ~(|imm[31:12]);
    case (op)
      OP_ADDI, OP_LW, OP_SW: imm_in_range = fits12;
      OP_SRAI:               imm_in_range = ~(|imm[31:5]);
      OP_BEQ:                imm_in_range = fits13 & ~imm[0];
      default:               imm_in_range = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/instr_encoder_imm_field_packer.sv
// Combinational RV32I field placement for one encoder request plus an illegal flag.
// IMM_RANGE_CHECK_EN adds immediate range rejection; otherwise immediates are truncated.
module imm_field_packer
  import riscv_isa_pkg::*;
(
  input  enc_req_t    req_i,
  output logic [31:0] word_o,
  output logic        illegal_o
);

  logic        op_bad;
  logic [31:0] imm;

  always_comb begin
    imm    = req_i.imm;
    word_o = '0;
    op_bad = 1'b0;
    case (req_i.op)
      OP_ADDI: word_o = {imm[11:0], req_i.rs1, F3_ADDI, req_i.rd, OPC_OPIMM};
      OP_LW:   word_o = {imm[11:0], req_i.rs1, F3_LW, req_i.rd, OPC_LOAD};
      OP_SRAI: word_o = {F7_SRA, imm[4:0], req_i.rs1, F3_SRX, req_i.rd, OPC_OPIMM};
      OP_SW:   word_o = {imm[11:5], req_i.rs2, req_i.rs1, F3_SW, imm[4:0], OPC_STORE};
      OP_BEQ:  word_o = {imm[12], imm[10:5], req_i.rs2, req_i.rs1, F3_BEQ,
                         imm[4:1], imm[11], OPC_BRANCH};
      default: op_bad = 1'b1;
    endcase
  end

`ifdef IMM_RANGE_CHECK_EN
  assign illegal_o = op_bad | ~imm_in_range(req_i.op, req_i.imm);
`else
  logic unused_imm_hi;
  assign unused_imm_hi = ^req_i.imm[31:13];
  assign illegal_o     = op_bad;
`endif

endmodule

// File: rtl/instr_encoder.sv
// Two-stage valid/ready RV32I encoder: stage A holds request fields, stage B the packed word.
// Immediate range checking is enabled with IMM_RANGE_CHECK_EN.
module instr_encoder
  import riscv_isa_pkg::*;
#(
  parameter int          CNT_W    = 16,
  parameter logic [31:0] NOP_WORD = NOP_INSTR
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [2:0]       op_i,
  input  logic [4:0]       rd_i,
  input  logic [4:0]       rs1_i,
  input  logic [4:0]       rs2_i,
  input  logic [31:0]      imm_i,
  output logic             instr_valid_o,
  input  logic             instr_ready_i,
  output logic [31:0]      instr_o,
  output logic             err_o,
  output logic [CNT_W-1:0] count_o
);

  logic             a_vld_q, a_vld_d;
  enc_req_t         a_req_q, a_req_d;
  logic             b_vld_q, b_vld_d;
  logic [31:0]      b_instr_q, b_instr_d;
  logic             b_err_q, b_err_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic        accept, handoff, b_load;
  logic [31:0] pack_word;
  logic        pack_illegal;

  imm_field_packer u_packer (
    .req_i     (a_req_q),
    .word_o    (pack_word),
    .illegal_o (pack_illegal)
  );

  assign req_ready_o = !a_vld_q || !b_vld_q || instr_ready_i;
  assign accept      = req_valid_i && req_ready_o;
  assign handoff     = b_vld_q && instr_ready_i;
  // A moves into B whenever B is empty or emptying this cycle.
  assign b_load      = a_vld_q && (!b_vld_q || instr_ready_i);

  always_comb begin
    a_vld_d   = a_vld_q;
    a_req_d   = a_req_q;
    b_vld_d   = b_vld_q;
    b_instr_d = b_instr_q;
    b_err_d   = b_err_q;
    count_d   = count_q;
    if (b_load)       a_vld_d = 1'b0;
    if (accept) begin
      a_vld_d = 1'b1;
      a_req_d = '{op: op_i, rd: rd_i, rs1: rs1_i, rs2: rs2_i, imm: imm_i};
    end
    if (handoff) begin
      b_vld_d = 1'b0;
      count_d = count_q + 1'b1;
    end
    if (b_load) begin
      b_vld_d   = 1'b1;
      b_instr_d = pack_illegal ? NOP_WORD : pack_word;
      b_err_d   = pack_illegal;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      a_vld_q   <= 1'b0;
      a_req_q   <= '0;
      b_vld_q   <= 1'b0;
      b_instr_q <= '0;
      b_err_q   <= 1'b0;
      count_q   <= '0;
    end else begin
      a_vld_q   <= a_vld_d;
      a_req_q   <= a_req_d;
      b_vld_q   <= b_vld_d;
      b_instr_q <= b_instr_d;
      b_err_q   <= b_err_d;
      count_q   <= count_d;
    end
  end

  assign instr_valid_o = b_vld_q;
  assign instr_o       = b_instr_q;
  assign err_o         = b_err_q;
  assign count_o       = count_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder; expectations follow IMM_RANGE_CHECK_EN when defined.
module tb_instr_encoder;
  import riscv_isa_pkg::*;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready;
  logic [2:0]    op;
  logic [4:0]    rd, rs1, rs2;
  logic [31:0]   imm;
  logic          instr_valid, instr_ready;
  logic [31:0]   instr;
  logic          err;
  logic [CW-1:0] count;

  int            n_cmp = 0;
  int            n_err = 0;
  logic [CW-1:0] exp_cnt;

  always #5 clk = ~clk;

  instr_encoder #(.CNT_W(CW), .NOP_WORD(32'h0000_0013)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .op_i(op), .rd_i(rd), .rs1_i(rs1), .rs2_i(rs2), .imm_i(imm),
    .instr_valid_o(instr_valid), .instr_ready_i(instr_ready),
    .instr_o(instr), .err_o(err), .count_o(count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: got %h want %h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] o, input logic [4:0] d, input logic [4:0] s1,
                       input logic [4:0] s2, input logic [31:0] im);
    op = o; rd = d; rs1 = s1; rs2 = s2; imm = im;
    req_valid = 1'b1;
  endtask

  // One request through an empty pipeline with instr_ready high.
  task automatic do_one(input string tag, input logic [2:0] o, input logic [4:0] d,
                        input logic [4:0] s1, input logic [4:0] s2, input logic [31:0] im,
                        input logic [31:0] ew, input logic ee);
    drive(o, d, s1, s2, im);
    chk({tag, " rdy"}, {31'd0, req_ready}, 32'd1);
    tick();
    req_valid = 1'b0;
    chk({tag, " lat1"}, {31'd0, instr_valid}, 32'd0);
    tick();
    chk({tag, " vld"}, {31'd0, instr_valid}, 32'd1);
    chk({tag, " word"}, instr, ew);
    chk({tag, " err"}, {31'd0, err}, {31'd0, ee});
    tick();
    exp_cnt = exp_cnt + 1'b1;
    chk({tag, " cnt"}, {28'd0, count}, {28'd0, exp_cnt});
  endtask

  initial begin
    rst = 1'b0; req_valid = 1'b0; instr_ready = 1'b1;
    op = '0; rd = '0; rs1 = '0; rs2 = '0; imm = '0;
    exp_cnt = '0;
    tick(); tick();
    chk("rst vld", {31'd0, instr_valid}, 32'd0);
    chk("rst word", instr, 32'd0);
    chk("rst err", {31'd0, err}, 32'd0);
    chk("rst cnt", {28'd0, count}, 32'd0);
    chk("rst rdy", {31'd0, req_ready}, 32'd1);
    rst = 1'b1;
    tick();

    do_one("addi", OP_ADDI, 5'd1, 5'd0, 5'd0, 32'd5, 32'h0050_0093, 1'b0);
    do_one("sw", OP_SW, 5'd0, 5'd3, 5'd2, 32'd8, 32'h0021_A423, 1'b0);
    do_one("srai", OP_SRAI, 5'd5, 5'd5, 5'd0, 32'd3, 32'h4032_D293, 1'b0);
    do_one("beq-4", OP_BEQ, 5'd0, 5'd1, 5'd2, -32'sd4, 32'hFE20_8EE3, 1'b0);
    do_one("addi-2048", OP_ADDI, 5'd0, 5'd0, 5'd0, -32'sd2048, 32'h8000_0013, 1'b0);
    do_one("op6", 3'd6, 5'd1, 5'd1, 5'd1, 32'd1, 32'h0000_0013, 1'b1);
`ifdef IMM_RANGE_CHECK_EN
    do_one("beq3", OP_BEQ, 5'd0, 5'd1, 5'd2, 32'd3, 32'h0000_0013, 1'b1);
    do_one("beq4096", OP_BEQ, 5'd0, 5'd1, 5'd2, 32'd4096, 32'h0000_0013, 1'b1);
    do_one("addi2048", OP_ADDI, 5'd0, 5'd0, 5'd0, 32'd2048, 32'h0000_0013, 1'b1);
    do_one("srai32", OP_SRAI, 5'd0, 5'd0, 5'd0, 32'd32, 32'h0000_0013, 1'b1);
`else
    do_one("beq3", OP_BEQ, 5'd0, 5'd1, 5'd2, 32'd3, 32'h0020_8163, 1'b0);
    do_one("beq4096", OP_BEQ, 5'd0, 5'd1, 5'd2, 32'd4096, 32'h8020_8063, 1'b0);
    do_one("addi2048", OP_ADDI, 5'd0, 5'd0, 5'd0, 32'd2048, 32'h8000_0013, 1'b0);
    do_one("srai32", OP_SRAI, 5'd0, 5'd0, 5'd0, 32'd32, 32'h4000_5013, 1'b0);
`endif

    // Back-to-back stream against a stalled consumer.
    instr_ready = 1'b0;
    drive(OP_ADDI, 5'd1, 5'd0, 5'd0, 32'd5);
    tick();
    chk("stall rdy1", {31'd0, req_ready}, 32'd1);
    drive(OP_SW, 5'd0, 5'd3, 5'd2, 32'd8);
    tick();
    chk("stall full", {31'd0, req_ready}, 32'd0);
    chk("stall vld", {31'd0, instr_valid}, 32'd1);
    chk("stall w1", instr, 32'h0050_0093);
    drive(OP_SRAI, 5'd5, 5'd5, 5'd0, 32'd3);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("stall hold", instr, 32'h0050_0093);
      chk("stall rdy", {31'd0, req_ready}, 32'd0);
    end
    instr_ready = 1'b1;
    tick();
    req_valid = 1'b0;
    exp_cnt = exp_cnt + 1'b1;
    chk("drain w2", instr, 32'h0021_A423);
    chk("drain vld2", {31'd0, instr_valid}, 32'd1);
    tick();
    exp_cnt = exp_cnt + 1'b1;
    chk("drain w3", instr, 32'h4032_D293);
    tick();
    exp_cnt = exp_cnt + 1'b1;
    chk("drain empty", {31'd0, instr_valid}, 32'd0);
    chk("drain cnt", {28'd0, count}, {28'd0, exp_cnt});

    // Reset with both stages occupied.
    instr_ready = 1'b0;
    drive(OP_ADDI, 5'd2, 5'd0, 5'd0, 32'd7);
    tick();
    drive(OP_LW, 5'd3, 5'd4, 5'd0, 32'd16);
    tick();
    req_valid = 1'b0;
    chk("full vld", {31'd0, instr_valid}, 32'd1);
    chk("full rdy", {31'd0, req_ready}, 32'd0);
    rst = 1'b0;
    tick();
    chk("mrst vld", {31'd0, instr_valid}, 32'd0);
    chk("mrst cnt", {28'd0, count}, 32'd0);
    chk("mrst rdy", {31'd0, req_ready}, 32'd1);
    chk("mrst word", instr, 32'd0);
    rst = 1'b1;
    exp_cnt = '0;
    instr_ready = 1'b1;
    tick(); tick();
    chk("mrst flushed", {31'd0, instr_valid}, 32'd0);

    do_one("lw", OP_LW, 5'd3, 5'd4, 5'd0, 32'd16, 32'h0102_2183, 1'b0);
    // Counter wrap.
    while (exp_cnt != 4'hF)
      do_one("fill", OP_ADDI, 5'd1, 5'd0, 5'd0, 32'd5, 32'h0050_0093, 1'b0);
    do_one("wrap", 3'd7, 5'd0, 5'd0, 5'd0, 32'd0, 32'h0000_0013, 1'b1);
    chk("wrap zero", {28'd0, count}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
